// File: rtl/prog_load_ctrl.sv
// Boot/run sequencer for the RV32I core: streams a program image into
// instruction memory, holds the core in reset, then gates run/halt/step.
module prog_load_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              word_valid,
  input  logic [31:0]       word_data,
  output logic              word_ready,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_data,
  output logic              core_rst,
  output logic              core_run,
  input  logic              halt_req,
  input  logic              resume_req,
  input  logic              step_req,
  output logic              len_err,
  output logic              busy,
  output logic [31:0]       cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ZERO  = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] CNT_ZERO  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] CNT_ONE   = ADDR_W'(1);
  localparam logic [3:0]        HOLD_LAST = 4'(RST_CYCLES);

  state_t            state_r;
  state_t            state_s;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W-1:0] cnt_r;
  logic [3:0]        hold_cnt_r;
  logic              imem_en_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_data_r;
  logic              core_rst_r;
  logic              core_run_r;
  logic              len_err_r;
  logic [31:0]       cycle_cnt_r;

  logic              len_ok_s;
  logic              xfer_s;
  logic              last_s;
  logic              step_s;
  logic              core_rst_s;
  logic              core_run_s;
  logic              len_err_s;

  assign len_ok_s = (load_len != LEN_ZERO) && (load_len <= DEPTH_L);
  assign xfer_s   = (state_r == S_LOAD) && word_valid;
  assign last_s   = ({1'b0, cnt_r} == (len_r - LEN_ONE));
  // load_start and resume_req both outrank a step request while halted
  assign step_s   = (state_r == S_HALT) && step_req && !load_start && !resume_req;

  assign word_ready = (state_r == S_LOAD);
  assign busy       = (state_r == S_LOAD) || (state_r == S_HOLD);
  assign imem_en    = imem_en_r;
  assign imem_addr  = imem_addr_r;
  assign imem_data  = imem_data_r;
  assign core_rst   = core_rst_r;
  assign core_run   = core_run_r;
  assign len_err    = len_err_r;
  assign cycle_cnt  = cycle_cnt_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (load_start && len_ok_s) state_s = S_LOAD;
        else                        state_s = S_IDLE;
      end
      S_LOAD: begin
        if (xfer_s && last_s) state_s = S_HOLD;
        else                  state_s = S_LOAD;
      end
      S_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) state_s = S_RUN;
        else                         state_s = S_HOLD;
      end
      S_RUN: begin
        if (halt_req) state_s = S_HALT;
        else          state_s = S_RUN;
      end
      S_HALT: begin
        if (load_start && len_ok_s) state_s = S_LOAD;
        else if (load_start)        state_s = S_HALT;
        else if (resume_req)        state_s = S_RUN;
        else                        state_s = S_HALT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of the registered control outputs, decoded from the next state
  always_comb begin
    core_rst_s = 1'b1;
    case (state_s)
      S_IDLE, S_LOAD, S_HOLD: core_rst_s = 1'b1;
      S_RUN, S_HALT:          core_rst_s = 1'b0;
      default:                core_rst_s = 1'b1;
    endcase
    core_run_s = (state_s == S_RUN) || step_s;
    len_err_s  = load_start && !len_ok_s && ((state_r == S_IDLE) || (state_r == S_HALT));
  end

  // Registered outputs, word counter, hold timer and cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_en_r   <= 1'b0;
      imem_addr_r <= CNT_ZERO;
      imem_data_r <= 32'd0;
      core_rst_r  <= 1'b1;
      core_run_r  <= 1'b0;
      len_err_r   <= 1'b0;
      cycle_cnt_r <= 32'd0;
      len_r       <= LEN_ZERO;
      cnt_r       <= CNT_ZERO;
      hold_cnt_r  <= 4'd0;
    end else begin
      imem_en_r  <= xfer_s;
      core_rst_r <= core_rst_s;
      core_run_r <= core_run_s;
      len_err_r  <= len_err_s;
      if (xfer_s) begin
        imem_addr_r <= cnt_r;
        imem_data_r <= word_data;
      end else begin
        imem_addr_r <= imem_addr_r;
        imem_data_r <= imem_data_r;
      end
      if ((state_r != S_LOAD) && (state_s == S_LOAD)) begin
        len_r <= load_len;
        cnt_r <= CNT_ZERO;
      end else if (xfer_s) begin
        len_r <= len_r;
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        len_r <= len_r;
        cnt_r <= cnt_r;
      end
      // Timer starts at zero on the cycle the final write is presented
      if (state_r == S_HOLD) hold_cnt_r <= hold_cnt_r + 4'd1;
      else                   hold_cnt_r <= 4'd0;
      if (state_s == S_HOLD)  cycle_cnt_r <= 32'd0;
      else if (core_run_r)    cycle_cnt_r <= cycle_cnt_r + 32'd1;
      else                    cycle_cnt_r <= cycle_cnt_r;
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed self-checking bench for prog_load_ctrl: load, hold, run,
// halt/step/resume, length errors, aborted loads and a full-depth load.
module tb_prog_load_ctrl;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              word_valid;
  logic [31:0]       word_data;
  logic              word_ready;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic              core_rst;
  logic              core_run;
  logic              halt_req;
  logic              resume_req;
  logic              step_req;
  logic              len_err;
  logic              busy;
  logic [31:0]       cycle_cnt;

  int checks = 0;
  int errors = 0;

  prog_load_ctrl #(.ADDR_W(8), .DEPTH(256), .RST_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_len(load_len),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .core_rst(core_rst), .core_run(core_run), .halt_req(halt_req),
    .resume_req(resume_req), .step_req(step_req), .len_err(len_err),
    .busy(busy), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; load_start = 1'b0; load_len = 9'd0; word_valid = 1'b0;
    word_data = 32'd0; halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
    tick; tick;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({core_rst, core_run, imem_en, len_err, word_ready, busy} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got rst/run/en/err/rdy/busy=%b exp 100000",
               {core_rst, core_run, imem_en, len_err, word_ready, busy});
    end
    checks++;
    if ({imem_addr, imem_data, cycle_cnt} !== {8'd0, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_data got addr=%h data=%h cnt=%0d exp 0/0/0", imem_addr, imem_data, cycle_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_load;
    logic [31:0] w [3];
    w[0] = 32'h00500093; w[1] = 32'h00108113; w[2] = 32'h0000006F;
    load_start = 1'b1; load_len = 9'd3; tick; load_start = 1'b0;
    checks++;
    if ({word_ready, busy, core_rst} !== 3'b111) begin
      errors++; $display("FAIL basic_enter_load got rdy/busy/rst=%b exp 111", {word_ready, busy, core_rst});
    end
    for (int i = 0; i < 3; i++) begin
      word_valid = 1'b1; word_data = w[i]; tick;
      checks++;
      if ({imem_en, imem_addr, imem_data} !== {1'b1, 8'(i), w[i]}) begin
        errors++;
        $display("FAIL basic_write%0d got en=%b addr=%h data=%h exp 1/%h/%h", i, imem_en, imem_addr, imem_data, 8'(i), w[i]);
      end
    end
    checks++;
    if (word_ready !== 1'b0) begin
      errors++; $display("FAIL basic_ready_low got %b exp 0", word_ready);
    end
    word_data = 32'hFFFFFFFF;
    for (int k = 1; k <= 4; k++) begin
      tick;
      checks++;
      if ({imem_en, core_rst, core_run} !== 3'b010) begin
        errors++; $display("FAIL basic_hold%0d got en/rst/run=%b exp 010", k, {imem_en, core_rst, core_run});
      end
    end
    tick;
    checks++;
    if ({core_rst, core_run, cycle_cnt} !== {2'b01, 32'd0}) begin
      errors++; $display("FAIL basic_run_start got rst/run=%b cnt=%0d exp 01/0", {core_rst, core_run}, cycle_cnt);
    end
    word_valid = 1'b0; tick; tick;
    checks++;
    if (cycle_cnt !== 32'd2) begin
      errors++; $display("FAIL basic_cycle_cnt got %0d exp 2", cycle_cnt);
    end
  endtask

  task automatic test_run_ignores_load;
    load_start = 1'b1; load_len = 9'd3; tick; load_start = 1'b0;
    checks++;
    if ({busy, core_run, word_ready, cycle_cnt} !== {3'b010, 32'd3}) begin
      errors++;
      $display("FAIL run_ignore_load got busy/run/rdy=%b cnt=%0d exp 010/3", {busy, core_run, word_ready}, cycle_cnt);
    end
  endtask

  task automatic test_halt_step;
    logic [31:0] exp_cnt [12];
    logic        exp_run [12];
    for (int i = 0; i < 7; i++) tick;
    checks++;
    if (cycle_cnt !== 32'd10) begin
      errors++; $display("FAIL halt_pre_cnt got %0d exp 10", cycle_cnt);
    end
    halt_req = 1'b1; tick; halt_req = 1'b0;
    checks++;
    if ({core_run, cycle_cnt} !== {1'b0, 32'd11}) begin
      errors++; $display("FAIL halt_enter got run=%b cnt=%0d exp 0/11", core_run, cycle_cnt);
    end
    tick; tick;
    checks++;
    if ({core_run, cycle_cnt} !== {1'b0, 32'd11}) begin
      errors++; $display("FAIL halt_frozen got run=%b cnt=%0d exp 0/11", core_run, cycle_cnt);
    end
    // two back-to-back steps, one isolated step, resume, then halt+resume together
    exp_run[0] = 1'b1; exp_cnt[0] = 32'd11;
    exp_run[1] = 1'b1; exp_cnt[1] = 32'd12;
    exp_run[2] = 1'b0; exp_cnt[2] = 32'd13;
    exp_run[3] = 1'b1; exp_cnt[3] = 32'd13;
    exp_run[4] = 1'b0; exp_cnt[4] = 32'd14;
    exp_run[5] = 1'b1; exp_cnt[5] = 32'd14;
    exp_run[6] = 1'b1; exp_cnt[6] = 32'd15;
    exp_run[7] = 1'b1; exp_cnt[7] = 32'd16;
    exp_run[8] = 1'b1; exp_cnt[8] = 32'd17;
    exp_run[9] = 1'b0; exp_cnt[9] = 32'd18;
    exp_run[10] = 1'b0; exp_cnt[10] = 32'd18;
    exp_run[11] = 1'b0; exp_cnt[11] = 32'd18;
    for (int i = 0; i < 12; i++) begin
      step_req   = (i == 0) || (i == 1) || (i == 3);
      resume_req = (i == 5) || (i == 9);
      halt_req   = (i == 9);
      tick;
      checks++;
      if ({core_run, cycle_cnt} !== {exp_run[i], exp_cnt[i]}) begin
        errors++;
        $display("FAIL halt_step%0d got run=%b cnt=%0d exp %b/%0d", i, core_run, cycle_cnt, exp_run[i], exp_cnt[i]);
      end
    end
    step_req = 1'b0; resume_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic test_halt_reload;
    load_start = 1'b1; load_len = 9'd0; tick; load_start = 1'b0;
    checks++;
    if ({len_err, busy, core_rst, core_run} !== 4'b1000) begin
      errors++; $display("FAIL halt_len_err got err/busy/rst/run=%b exp 1000", {len_err, busy, core_rst, core_run});
    end
    load_start = 1'b1; load_len = 9'd1; resume_req = 1'b1; step_req = 1'b1; tick;
    load_start = 1'b0; resume_req = 1'b0; step_req = 1'b0;
    checks++;
    if ({len_err, busy, core_rst, word_ready, core_run} !== 5'b01110) begin
      errors++;
      $display("FAIL halt_reload got err/busy/rst/rdy/run=%b exp 01110", {len_err, busy, core_rst, word_ready, core_run});
    end
    word_valid = 1'b1; word_data = 32'h0000006F; tick; word_valid = 1'b0;
    checks++;
    if ({imem_en, imem_addr, imem_data, word_ready} !== {1'b1, 8'd0, 32'h0000006F, 1'b0}) begin
      errors++;
      $display("FAIL halt_reload_write got en=%b addr=%h data=%h rdy=%b exp 1/00/0000006f/0", imem_en, imem_addr, imem_data, word_ready);
    end
  endtask

  task automatic test_len_err;
    logic [8:0] bad [2];
    bad[0] = 9'd0; bad[1] = 9'd257;
    do_reset; rst = 1'b0;
    word_valid = 1'b1; word_data = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      load_start = 1'b1; load_len = bad[i]; tick; load_start = 1'b0;
      checks++;
      if ({len_err, busy, word_ready, imem_en, core_rst} !== 5'b10001) begin
        errors++;
        $display("FAIL len_err%0d got err/busy/rdy/en/rst=%b exp 10001", i, {len_err, busy, word_ready, imem_en, core_rst});
      end
      tick;
      checks++;
      if ({len_err, busy, imem_en} !== 3'b000) begin
        errors++; $display("FAIL len_err_clear%0d got err/busy/en=%b exp 000", i, {len_err, busy, imem_en});
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic test_gapped_load;
    logic        v [6];
    logic [7:0]  idx;
    v[0] = 1'b1; v[1] = 1'b0; v[2] = 1'b0; v[3] = 1'b1; v[4] = 1'b0; v[5] = 1'b1;
    do_reset; rst = 1'b0;
    load_start = 1'b1; load_len = 9'd3; tick; load_start = 1'b0;
    idx = 8'd0;
    for (int i = 0; i < 6; i++) begin
      word_valid = v[i]; word_data = 32'hC0DE0000 + 32'(i); tick;
      checks++;
      if (v[i]) begin
        if ({busy, imem_en, imem_addr, imem_data} !== {2'b11, idx, 32'hC0DE0000 + 32'(i)}) begin
          errors++;
          $display("FAIL gap_write%0d got busy=%b en=%b addr=%h data=%h exp 1/1/%h/%h", i, busy, imem_en, imem_addr, imem_data, idx, 32'hC0DE0000 + 32'(i));
        end
        idx = idx + 8'd1;
      end else begin
        if ({busy, imem_en} !== 2'b10) begin
          errors++; $display("FAIL gap_idle%0d got busy/en=%b exp 10", i, {busy, imem_en});
        end
      end
    end
    word_valid = 1'b0;
    checks++;
    if (word_ready !== 1'b0) begin
      errors++; $display("FAIL gap_ready_low got %b exp 0", word_ready);
    end
  endtask

  task automatic test_reset_abort;
    do_reset; rst = 1'b0;
    load_start = 1'b1; load_len = 9'd5; tick; load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      word_valid = 1'b1; word_data = 32'h0BAD0000 + 32'(i); tick;
    end
    rst = 1'b1; tick;
    checks++;
    if ({imem_en, core_rst, busy, word_ready} !== 4'b0100) begin
      errors++; $display("FAIL abort_rst got en/rst/busy/rdy=%b exp 0100", {imem_en, core_rst, busy, word_ready});
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if ({imem_en, core_rst, busy} !== 3'b010) begin
        errors++; $display("FAIL abort_idle%0d got en/rst/busy=%b exp 010", i, {imem_en, core_rst, busy});
      end
    end
    word_valid = 1'b0;
    load_start = 1'b1; load_len = 9'd1; tick; load_start = 1'b0;
    word_valid = 1'b1; word_data = 32'hDEADBEEF; tick; word_valid = 1'b0;
    checks++;
    if ({imem_en, imem_addr, imem_data} !== {1'b1, 8'd0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL abort_reload got en=%b addr=%h data=%h exp 1/00/deadbeef", imem_en, imem_addr, imem_data);
    end
  endtask

  task automatic test_full_load;
    do_reset; rst = 1'b0;
    load_start = 1'b1; load_len = 9'd256; tick; load_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      word_valid = 1'b1; word_data = 32'hA5A50000 ^ 32'(i); tick;
      checks++;
      if ({imem_en, imem_addr, imem_data} !== {1'b1, 8'(i), 32'hA5A50000 ^ 32'(i)}) begin
        errors++;
        $display("FAIL full_write%0d got en=%b addr=%h data=%h", i, imem_en, imem_addr, imem_data);
      end
    end
    word_data = 32'h00000000; tick;
    checks++;
    if ({imem_en, word_ready, busy, imem_addr} !== {3'b001, 8'hFF}) begin
      errors++;
      $display("FAIL full_end got en/rdy/busy=%b addr=%h exp 001/ff", {imem_en, word_ready, busy}, imem_addr);
    end
    word_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic_load;
    test_run_ignores_load;
    test_halt_step;
    test_halt_reload;
    test_len_err;
    test_gapped_load;
    test_reset_abort;
    test_full_load;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_load_ctrl.md
Name: prog_load_ctrl

Overview:
- Boot and run sequencer for the single-cycle RV32I microprocessor.
- Accepts a program image as a stream of 32-bit words over a valid/ready handshake and writes it sequentially into instruction memory.
- Holds the core in reset while loading, then releases it and gates execution with run, halt and single-step control.
- Counts executed cycles for debug and performance measurement.

Parameters:
- ADDR_W, 8, instruction memory word-address width (matches PC bits [9:2]).
- DEPTH, 256, instruction memory depth in words (2**ADDR_W).
- RST_CYCLES, 4, number of cycles core_rst is held high after the last word is written, before the core runs; valid range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle pulse that begins a load session
- load_len  in  ADDR_W+1  number of words to load; valid range 1..DEPTH
- word_valid  in  1  word_data is valid this cycle
- word_data  in  32  instruction word
- word_ready  out  1  controller accepts a word this cycle
- imem_en  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  instruction memory word address
- imem_data  out  32  instruction memory write data
- core_rst  out  1  reset to the microprocessor
- core_run  out  1  clock enable for the core's state (PC, register file, data memory)
- halt_req  in  1  request to halt the core
- resume_req  in  1  request to resume free-running execution
- step_req  in  1  request to execute one cycle while halted
- len_err  out  1  one-cycle pulse: load_start was given with an illegal load_len
- busy  out  1  high in LOAD or HOLD
- cycle_cnt  out  32  number of core_run-enabled cycles since the last load

Behaviour:
- The state machine has five states: IDLE, LOAD, HOLD, RUN, HALT. All outputs are registered except word_ready and busy, which decode the current state.
- On rst the block enters IDLE with:
  - core_rst=1, core_run=0, imem_en=0, imem_addr=0, imem_data=0
  - len_err=0, cycle_cnt=0, word_ready=0, busy=0
  - the internal word counter cleared.
- rst in the middle of a load aborts the session. Already-written instruction memory words are left in place and no further writes occur.
- IDLE:
  - core_rst=1.
  - load_start with load_len in 1..DEPTH: latch the length, clear the word counter, go to LOAD.
  - load_start with load_len=0 or load_len>DEPTH: len_err=1 for one cycle, stay in IDLE.
  - word_valid is ignored.
- LOAD:
  - word_ready=1 and core_rst=1.
  - A transfer occurs when word_valid and word_ready are both high.
  - One cycle after each transfer: imem_en=1, imem_addr=counter value at transfer, imem_data=word_data. Write latency is 1 cycle.
  - imem_en=0 on every cycle that follows no transfer.
  - Gaps in word_valid are allowed; the counter holds across them.
  - The transfer with counter == len-1 moves the FSM to HOLD. word_ready is low from the next cycle, so exactly len words are accepted and counter addresses are never reused.
  - A load of DEPTH words ends at address DEPTH-1 with no wrap.
  - load_start during LOAD is ignored.
- HOLD:
  - core_rst=1 for exactly RST_CYCLES cycles, counted from the cycle after the final imem_en pulse; then go to RUN.
  - cycle_cnt is cleared on entry.
- RUN:
  - core_rst=0, core_run=1, cycle_cnt increments by 1 each cycle and wraps modulo 2^32.
  - halt_req: go to HALT; core_run=0 starting the next cycle.
  - load_start is ignored in RUN.
- HALT:
  - core_rst=0, core_run=0 by default.
  - step_req: core_run=1 for exactly one cycle and cycle_cnt increments by 1. Back-to-back step_req pulses give one cycle each.
  - resume_req: go to RUN.
  - load_start with a legal load_len: core_rst=1 next cycle, go to LOAD.
  - load_start with an illegal load_len: len_err pulse, stay in HALT.
- Priority for simultaneous requests in HALT: load_start > resume_req > step_req.
- halt_req together with resume_req in RUN: halt_req wins.
- halt_req, resume_req and step_req are ignored in IDLE, LOAD and HOLD.

Test Plan:
- rst, then load_start with load_len=3 and words 0x00500093, 0x00108113, 0x0000006F with word_valid always high -> imem_en pulses at addresses 0, 1, 2 with matching data; word_ready low after the third transfer; core_rst falls exactly 4 cycles after the last imem_en; cycle_cnt counts from 0.
- Same load with word_valid toggling 1,0,0,1,0,1 -> exactly 3 writes to addresses 0..2; no write on idle cycles; busy high throughout.
- load_start with load_len=0 and then with 257 -> len_err pulses once for each; state stays IDLE; no imem_en activity.
- In RUN after 10 cycles, halt_req -> core_run=0 next cycle and cycle_cnt frozen; three step_req pulses -> cycle_cnt +3 and core_run high for 3 single cycles; resume_req -> free run resumes.
- rst asserted after 2 of 5 words -> IDLE, core_rst=1, no further writes; a new load of 1 word writes address 0.
- Load 256 words back-to-back -> last write at address 255; HOLD entered; no write to address 0 after the last word.
